// File: rtl/button_pulser_pkg.sv
// rtl/button_pulser_pkg.sv - shared FSM encoding, default timing and sizing helpers for button_pulser
package button_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCKED = 2'd3
  } chan_state_e;

  // 10 ms debounce, 0.5 s initial repeat delay, 0.1 s repeat period at 50 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit above $clog2 so the terminal count always fits without wrapping
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/button_pulser_if.sv
// rtl/button_pulser_if.sv - per-button link between the top-level arbiter and one button_channel
interface button_pulser_if;
  logic btn_n;
  logic pressed;
  logic fire;
  logic lock;

  modport master (
    output btn_n,
    output lock,
    input  pressed,
    input  fire
  );

  modport slave (
    input  btn_n,
    input  lock,
    output pressed,
    output fire
  );
endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - synchronizer, debouncer and IDLE/DELAY/REPEAT/LOCKED FSM for one button
module button_channel
  import button_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic            clk,
  input logic            rst,
  button_pulser_if.slave ch
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned TM_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] RD_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RP_LAST = TM_W'(REPEAT_PERIOD - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            pressed_q, pressed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [TM_W-1:0] timer_q, timer_d;
  chan_state_e     state_q, state_d;
  logic            fire;
  logic            sync_pressed;

  always_comb begin
    sync1_d = ch.btn_n;
    sync2_d = sync1_q;
  end

  assign sync_pressed = ~sync2_q;

  // Counter only runs while the synchronized input disagrees with the accepted level
  always_comb begin
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if (sync_pressed != pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = ~pressed_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fire    = 1'b0;
    if (ch.lock) begin
      state_d = ST_LOCKED;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (pressed_q) begin
            state_d = ST_DELAY;
            fire    = 1'b1;
          end
        end
        ST_DELAY: begin
          if (!pressed_q) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == RD_LAST) begin
            state_d = ST_REPEAT;
            timer_d = '0;
            fire    = 1'b1;
          end else begin
            timer_d = timer_q + TM_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!pressed_q) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == RP_LAST) begin
            timer_d = '0;
            fire    = 1'b1;
          end else begin
            timer_d = timer_q + TM_W'(1);
          end
        end
        ST_LOCKED: begin
          timer_d = '0;
          if (!pressed_q) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
      timer_q   <= '0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
    end
  end

  assign ch.pressed = pressed_q;
  assign ch.fire    = fire;

endmodule

// File: rtl/button_pulser.sv
// rtl/button_pulser.sv - two debounced auto-repeat buttons with mutual lockout and active-low strobes
module button_pulser
  import button_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_n,
  input  logic btn_dn_n,
  output logic sum,
  output logic rest
);

  button_pulser_if up_ch ();
  button_pulser_if dn_ch ();

  logic lock_both;
  logic sum_q, sum_d;
  logic rest_q, rest_d;

  assign up_ch.btn_n = btn_up_n;
  assign dn_ch.btn_n = btn_dn_n;

  // Lock uses the registered debounced levels, so it never loops back through fire
  assign lock_both   = up_ch.pressed & dn_ch.pressed;
  assign up_ch.lock  = lock_both;
  assign dn_ch.lock  = lock_both;

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk (clk),
    .rst (rst),
    .ch  (up_ch)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dn (
    .clk (clk),
    .rst (rst),
    .ch  (dn_ch)
  );

  always_comb begin
    sum_d  = ~(up_ch.fire & ~dn_ch.fire);
    rest_d = ~(dn_ch.fire & ~up_ch.fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 1'b1;
      rest_q <= 1'b1;
    end else begin
      sum_q  <= sum_d;
      rest_q <= rest_d;
    end
  end

  assign sum  = sum_q;
  assign rest = rest_q;

endmodule

// File: tb/tb_button_pulser.sv
// tb/tb_button_pulser.sv - directed and randomized self-checking bench for button_pulser
module tb_button_pulser;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sum;
  logic rest;

  button_pulser_if up_if ();
  button_pulser_if dn_if ();

  always #5 clk = ~clk;

  button_pulser #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up_n (up_if.btn_n),
    .btn_dn_n (dn_if.btn_n),
    .sum      (sum),
    .rest     (rest)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference: press age since first strobe, strobes at age 0, RD, RD+k*RP
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_hist0[$];
  bit m_hist1[$];
  bit m_active[2];
  bit m_locked[2];
  int m_age[2];
  bit exp_low[2];

  logic prev_sum  = 1'b1;
  logic prev_rest = 1'b1;
  int   edge_idx;
  int   pulses_up[$];
  int   pulses_dn[$];

  function automatic bit all_differ(input bit hist[$], input bit lvl);
    if (hist.size() < D) return 1'b0;
    foreach (hist[i]) if (hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit old_lvl[2];
    bit both;
    bit raw[2];
    raw[0] = up_if.btn_n;
    raw[1] = dn_if.btn_n;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_lvl[c] = 1'b0;
        m_active[c] = 1'b0; m_locked[c] = 1'b0; m_age[c] = 0; exp_low[c] = 1'b0;
      end
      m_hist0.delete();
      m_hist1.delete();
      return;
    end
    old_lvl[0] = m_lvl[0];
    old_lvl[1] = m_lvl[1];
    both = old_lvl[0] && old_lvl[1];
    for (int c = 0; c < 2; c++) begin
      exp_low[c] = 1'b0;
      if (both) begin
        m_locked[c] = 1'b1;
        m_active[c] = 1'b0;
      end else if (m_locked[c]) begin
        if (!old_lvl[c]) m_locked[c] = 1'b0;
      end else if (!old_lvl[c]) begin
        m_active[c] = 1'b0;
      end else if (!m_active[c]) begin
        m_active[c] = 1'b1;
        m_age[c]    = 0;
        exp_low[c]  = 1'b1;
      end else begin
        m_age[c]   = m_age[c] + 1;
        exp_low[c] = (m_age[c] == RD) || (m_age[c] > RD && ((m_age[c] - RD) % RP) == 0);
      end
    end
    m_hist0.push_back(!m_s2[0]);
    m_hist1.push_back(!m_s2[1]);
    if (m_hist0.size() > D) void'(m_hist0.pop_front());
    if (m_hist1.size() > D) void'(m_hist1.pop_front());
    if (all_differ(m_hist0, old_lvl[0])) m_lvl[0] = !old_lvl[0];
    if (all_differ(m_hist1, old_lvl[1])) m_lvl[1] = !old_lvl[1];
    for (int c = 0; c < 2; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    tests_run++;
    assert (sum === ~exp_low[0]) else begin
      tests_failed++;
      $error("FAIL sum_model edge %0d: got %b expected %b", edge_idx, sum, ~exp_low[0]);
    end
    tests_run++;
    assert (rest === ~exp_low[1]) else begin
      tests_failed++;
      $error("FAIL rest_model edge %0d: got %b expected %b", edge_idx, rest, ~exp_low[1]);
    end
    tests_run++;
    assert (!(sum === 1'b0 && rest === 1'b0)) else begin
      tests_failed++;
      $error("FAIL both_low edge %0d: got sum=%b rest=%b expected not both 0", edge_idx, sum, rest);
    end
    tests_run++;
    assert (!((sum === 1'b0 && prev_sum === 1'b0) || (rest === 1'b0 && prev_rest === 1'b0))) else begin
      tests_failed++;
      $error("FAIL strobe_width edge %0d: got two low cycles expected one", edge_idx);
    end
    if (sum === 1'b0)  pulses_up.push_back(edge_idx);
    if (rest === 1'b0) pulses_dn.push_back(edge_idx);
    prev_sum  = sum;
    prev_rest = rest;
    edge_idx++;
  endtask

  task automatic begin_test();
    pulses_up.delete();
    pulses_dn.delete();
    edge_idx = 0;
  endtask

  task automatic settle(input int n);
    up_if.btn_n = 1'b1;
    dn_if.btn_n = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_pulses(input string tag, input int got[$], input int exp[$]);
    tests_run++;
    assert (got.size() == exp.size()) else begin
      tests_failed++;
      $error("FAIL %s_count: got %0d expected %0d", tag, got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      tests_run++;
      assert (got[i] == exp[i]) else begin
        tests_failed++;
        $error("FAIL %s_edge[%0d]: got %0d expected %0d", tag, i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    int exp_q[$];
    int hold[2];
    bit lvl[2];
    up_if.btn_n = 1'b1; dn_if.btn_n = 1'b1;
    up_if.lock = 1'b0; up_if.pressed = 1'b0; up_if.fire = 1'b0;
    dn_if.lock = 1'b0; dn_if.pressed = 1'b0; dn_if.fire = 1'b0;
    rst = 1'b1;
    edge_idx = 0;
    tick();
    tick();
    tests_run++;
    assert (sum === 1'b1 && rest === 1'b1) else begin
      tests_failed++;
      $error("FAIL reset_state: got sum=%b rest=%b expected 1 1", sum, rest);
    end
    rst = 1'b0;
    settle(10);

    // clean press on up
    begin_test();
    for (int e = 0; e < 40; e++) begin
      up_if.btn_n = (e < 10) ? 1'b0 : 1'b1;
      tick();
    end
    exp_q = {6};
    check_pulses("clean_sum", pulses_up, exp_q);
    exp_q.delete();
    check_pulses("clean_rest", pulses_dn, exp_q);
    settle(10);

    // bouncing press on up
    begin_test();
    for (int e = 0; e < 45; e++) begin
      if (e < 12) up_if.btn_n = ((e / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else        up_if.btn_n = (e < 30) ? 1'b0 : 1'b1;
      tick();
    end
    exp_q = {18};
    check_pulses("bounce_sum", pulses_up, exp_q);
    settle(10);

    // auto-repeat on down
    begin_test();
    for (int e = 0; e < 80; e++) begin
      dn_if.btn_n = (e < 60) ? 1'b0 : 1'b1;
      tick();
    end
    exp_q = {6, 26, 34, 42, 50, 58};
    check_pulses("repeat_rest", pulses_dn, exp_q);
    exp_q.delete();
    check_pulses("repeat_sum", pulses_up, exp_q);
    settle(10);

    // simultaneous press locks both, then a fresh up press works
    begin_test();
    for (int e = 0; e < 100; e++) begin
      up_if.btn_n = (e < 30 || (e >= 80 && e < 90)) ? 1'b0 : 1'b1;
      dn_if.btn_n = (e < 60) ? 1'b0 : 1'b1;
      tick();
    end
    exp_q = {86};
    check_pulses("lock_sum", pulses_up, exp_q);
    exp_q.delete();
    check_pulses("lock_rest", pulses_dn, exp_q);
    settle(10);

    // reset in the middle of a repeating hold
    begin_test();
    for (int e = 0; e < 80; e++) begin
      dn_if.btn_n = (e < 60) ? 1'b0 : 1'b1;
      rst = (e == 40 || e == 41);
      tick();
      if (e == 40 || e == 41) begin
        tests_run++;
        assert (rest === 1'b1) else begin
          tests_failed++;
          $error("FAIL rst_rest_high edge %0d: got %b expected 1", e, rest);
        end
      end
    end
    rst = 1'b0;
    exp_q = {6, 26, 34, 48};
    check_pulses("reset_rest", pulses_dn, exp_q);
    settle(10);

    // randomized hold/bounce patterns on both buttons
    begin_test();
    hold[0] = 0; hold[1] = 0; lvl[0] = 1'b1; lvl[1] = 1'b1;
    for (int e = 0; e < 4000; e++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = ~lvl[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 70);
        end
        hold[c]--;
      end
      up_if.btn_n = lvl[0];
      dn_if.btn_n = lvl[1];
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    settle(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
